// File: rtl/gjc_deser_if.sv
// rtl/gjc_deser_if.sv - serial input / parallel output bundle for gjc_deser
// master drives the serial side; slave is the deserialiser itself.
interface gjc_deser_if #(
   parameter int DATA_W = 8
);
   logic              enable;
   logic              data_i;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              locked_o;
   logic [7:0]        err_cnt_o;

   modport master (
      output enable, data_i,
      input  data_o, valid_o, locked_o, err_cnt_o
   );

   modport slave (
      input  enable, data_i,
      output data_o, valid_o, locked_o, err_cnt_o
   );
endinterface

// File: rtl/gjc_deser.sv
// rtl/gjc_deser.sv - GJC serial-to-parallel receiver with sync-word alignment
// Optional even-parity framing and error-driven loss of lock: GJC_DESER_PARITY_EN.
module gjc_deser #(
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] SYNC_PAT = 8'hA5,
   parameter int                IDLE_MAX = 16,
   parameter int                ERR_MAX  = 4
) (
   input  logic        clk_i,
   input  logic        reset_n,
   gjc_deser_if.slave  bus
);

`ifdef GJC_DESER_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif
   localparam int CW = $clog2(DATA_W + 2);
   localparam int IW = $clog2(IDLE_MAX + 1);

   localparam logic [CW-1:0] HUNT_SAT   = CW'(DATA_W);
   localparam logic [CW-1:0] HUNT_READY = CW'(DATA_W - 1);
   localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_MAX - 1);

   if (DATA_W < 2 || SYNC_PAT == '0 || IDLE_MAX < 1 || ERR_MAX < 1) begin : g_bad_param
      $error("gjc_deser: illegal parameter set");
   end

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] sr;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] word;
   logic [CW-1:0]     bit_cnt;
   logic [IW-1:0]     idle_cnt;
   logic              sync_hit;
   logic              frame_end;
   logic              idle_hit;
   logic              frame_good;
   logic              err_hit;
   logic              emit;

   assign shifted   = {sr[DATA_W-2:0], bus.data_i};
   assign sync_hit  = (state == HUNT) && bus.enable && (bit_cnt >= HUNT_READY)
                      && (shifted == SYNC_PAT);
   assign frame_end = (state == LOCKED) && bus.enable && (bit_cnt == FRAME_LAST);
   assign idle_hit  = (state == LOCKED) && !bus.enable && (idle_cnt == IDLE_LAST);

`ifdef GJC_DESER_PARITY_EN
   localparam int EW = $clog2(ERR_MAX + 1);
   localparam logic [EW-1:0] ERR_LAST = EW'(ERR_MAX - 1);

   logic [EW-1:0] cons_err;
   logic [7:0]    err_cnt;

   // On the parity bit the data bits are still whole in sr, the parity bit is on data_i.
   assign word       = sr;
   assign frame_good = ~^{sr, bus.data_i};
   assign err_hit    = frame_end && !frame_good && (cons_err == ERR_LAST);

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         cons_err <= '0;
         err_cnt  <= '0;
      end else if (sync_hit) begin
         cons_err <= '0;
      end else if (frame_end) begin
         if (frame_good) begin
            cons_err <= '0;
         end else begin
            cons_err <= err_hit ? '0 : cons_err + 1'b1;
            if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end
      end
   end

   assign bus.err_cnt_o = err_cnt;
`else
   assign word          = shifted;
   assign frame_good    = 1'b1;
   assign err_hit       = 1'b0;
   assign bus.err_cnt_o = 8'h00;
`endif

   // State register
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         HUNT:    if (sync_hit) state_nxt = LOCKED;
         LOCKED:  if (idle_hit || err_hit) state_nxt = HUNT;
         default: state_nxt = HUNT;
      endcase
   end

   // Output decode; a sync word inside a locked stream is only a keep-alive
   always_comb begin
      bus.locked_o = (state == LOCKED);
      emit         = frame_end && frame_good && (word != SYNC_PAT);
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         sr          <= '0;
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         bus.data_o  <= '0;
         bus.valid_o <= 1'b0;
      end else begin
         bus.valid_o <= 1'b0;
         if (emit) begin
            bus.data_o  <= word;
            bus.valid_o <= 1'b1;
         end

         if (idle_hit) begin
            sr <= '0;
         end else if (bus.enable) begin
            sr <= shifted;
         end

         if (state == HUNT) begin
            if (sync_hit) begin
               bit_cnt <= '0;
            end else if (bus.enable && (bit_cnt != HUNT_SAT)) begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else if (idle_hit || err_hit || frame_end) begin
            bit_cnt <= '0;
         end else if (bus.enable) begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if ((state == LOCKED) && !bus.enable && !idle_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
         end else begin
            idle_cnt <= '0;
         end
      end
   end

endmodule
